// File: rtl/bv2_unscl_sigma2_seq.sv
// Serial GF(2^2) unscaler: multiplies each 2-bit element of a word by W^-1 = W^2, one element per clock.
// Optional macro BV2_UNSCL_SELFCHECK_EN adds a shadow-register re-scale check with a sticky out_error port.
module bv2_unscl_sigma2_seq #(
    parameter  int NUM_ELEM = 8,
    localparam int CNT_W    = $clog2(NUM_ELEM)
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic                  in_valid,
    input  logic [2*NUM_ELEM-1:0] in_data,
    output logic                  out_in_ready,
    output logic                  out_valid,
    output logic [2*NUM_ELEM-1:0] out_data,
    input  logic                  in_out_ready,
`ifdef BV2_UNSCL_SELFCHECK_EN
    output logic                  out_error,
`endif
    output logic                  out_busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEM - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*NUM_ELEM-1:0]   data_q, data_d;

    // x * W^2: b1 = a0, b0 = a0 ^ a1
    function automatic logic [1:0] unscl(input logic [1:0] a);
        return {a[0], a[0] ^ a[1]};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < NUM_ELEM; k++) begin
                    if (cnt_q == CNT_W'(k))
                        data_d[2*k +: 2] = unscl(data_q[2*k +: 2]);
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (in_out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Ready is masked by reset so it reads low while reset is held.
    assign out_in_ready = (state_q == IDLE) && !in_reset;
    assign out_valid    = (state_q == DONE);
    assign out_data     = (state_q == DONE) ? data_q : '0;
    assign out_busy     = (state_q == BUSY);

`ifdef BV2_UNSCL_SELFCHECK_EN
    logic [2*NUM_ELEM-1:0] shadow_q, shadow_d;
    logic                  err_q, err_d;
    logic                  mism;

    // x * W: b1 = a0 ^ a1, b0 = a1
    function automatic logic [1:0] scl(input logic [1:0] a);
        return {a[0] ^ a[1], a[1]};
    endfunction

    always_comb begin
        mism = 1'b0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (scl(data_q[2*k +: 2]) != shadow_q[2*k +: 2])
                mism = 1'b1;
        end
        shadow_d = shadow_q;
        if (state_q == IDLE && in_valid)
            shadow_d = in_data;
        err_d = err_q | ((state_q == DONE) && mism);
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    assign out_error = err_q;
`endif

endmodule
